// File: rtl/neuron_spike_collector.sv
// Spike collector for the CIM macro neuron output port.
// Each REQ samples a 16-bit fire vector, tags it with the current time step and
// queues it. Queued vectors are unrolled into address events {ts, neuron index},
// lowest neuron first, one event per cycle over a valid/ready port.
//
// Handshake: an event transfers on a rising CLK edge where EVT_VALID and
// EVT_READY are both high. While EVT_VALID is high and EVT_READY is low, every
// EVT_* output holds its value, and EVT_VALID only drops after a transfer.
module neuron_spike_collector #(
   parameter int DEPTH = 4,  // FIFO entries, power of two, >= 2
   parameter int TS_W  = 8   // time-step tag width
) (
   input  logic            CLK,
   input  logic            RSTB,
   input  logic            CLR,
   input  logic            FRAME_START,
   input  logic            REQ,
   input  logic [15:0]     NEURON_OUT,
   output logic            EVT_VALID,
   input  logic            EVT_READY,
   output logic [TS_W-1:0] EVT_TS,
   output logic [3:0]      EVT_ADDR,
   output logic            EVT_LAST,
   output logic            OVF,
   output logic            BUSY
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = TS_W + 16;

   // Index of the lowest set bit; 0 for an all-zero vector.
   function automatic logic [3:0] lowest_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // FIFO storage and pointers
   logic [EW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Time-step counter and sticky overflow flag
   logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
   logic            ovf_q, ovf_d;

   // Drain register: vector currently being unrolled into events
   logic [TS_W-1:0] dr_ts_q, dr_ts_d;
   logic [15:0]     dr_vec_q, dr_vec_d;

   // Pre-decoded event fields so the outputs come straight from flops
   logic [3:0]      addr_q, addr_d;
   logic            last_q, last_d;

   // Internal control
   logic [EW-1:0]   head;
   logic [TS_W-1:0] req_tag;
   logic [15:0]     dr_vec_rem;
   logic            fifo_empty;
   logic            fifo_full;
   logic            xfer;
   logic            dr_free;
   logic            req_nz;
   logic            push;
   logic            pop;
   logic            drop;

   assign head       = mem_q[rd_ptr_q];
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CW'(DEPTH));

   // A REQ coinciding with FRAME_START opens the new frame, so it is tagged 0.
   assign req_tag    = FRAME_START ? '0 : ts_cnt_q;

   // Vector left over once the lowest set bit has been sent.
   assign dr_vec_rem = dr_vec_q & (dr_vec_q - 16'd1);
   assign xfer       = EVT_VALID && EVT_READY;

   // The drain register can take a new vector if it is idle, or if its final
   // event leaves at this edge (back-to-back vectors without a bubble).
   assign dr_free    = (dr_vec_q == '0) || (xfer && (dr_vec_rem == '0));
   assign pop        = !CLR && dr_free && !fifo_empty;

   // Zero vectors never occupy storage; a full FIFO still accepts a push when
   // it pops at the same edge.
   assign req_nz     = REQ && !CLR && (NEURON_OUT != '0);
   assign push       = req_nz && (!fifo_full || pop);
   assign drop       = req_nz && !push;

   // Time-step counter: every sampled REQ (zero vector or not) advances it.
   always_comb begin
      ts_cnt_d = ts_cnt_q;
      if (CLR) begin
         ts_cnt_d = '0;
      end else if (REQ) begin
         ts_cnt_d = req_tag + TS_W'(1);
      end else if (FRAME_START) begin
         ts_cnt_d = '0;
      end
   end

   // FIFO pointers, occupancy and overflow flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      if (CLR) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
         if (drop) ovf_d = 1'b1;
      end
   end

   // Drain register: load the FIFO head when free, else peel off sent bits.
   always_comb begin
      dr_ts_d  = dr_ts_q;
      dr_vec_d = dr_vec_q;
      if (CLR) begin
         dr_ts_d  = '0;
         dr_vec_d = '0;
      end else if (pop) begin
         dr_ts_d  = head[EW-1:16];
         dr_vec_d = head[15:0];
      end else if (xfer) begin
         dr_vec_d = dr_vec_rem;
         // Idle outputs read as zero once the last event has gone.
         if (dr_vec_rem == '0) dr_ts_d = '0;
      end
   end

   // Decode the next event's neuron index and last flag ahead of time.
   always_comb begin
      addr_d = lowest_idx(dr_vec_d);
      last_d = (dr_vec_d != '0) && ((dr_vec_d & (dr_vec_d - 16'd1)) == '0);
   end

   // Control and datapath state with asynchronous reset.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ts_cnt_q <= '0;
         ovf_q    <= 1'b0;
         dr_ts_q  <= '0;
         dr_vec_q <= '0;
         addr_q   <= '0;
         last_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ts_cnt_q <= ts_cnt_d;
         ovf_q    <= ovf_d;
         dr_ts_q  <= dr_ts_d;
         dr_vec_q <= dr_vec_d;
         addr_q   <= addr_d;
         last_q   <= last_d;
      end
   end

   // FIFO storage; contents are only meaningful behind the pointers, so no reset.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= {req_tag, NEURON_OUT};
   end

   assign EVT_VALID = (dr_vec_q != '0);
   assign EVT_TS    = dr_ts_q;
   assign EVT_ADDR  = addr_q;
   assign EVT_LAST  = last_q;
   assign OVF       = ovf_q;
   assign BUSY      = !fifo_empty || EVT_VALID;

endmodule

// File: tb/tb_neuron_spike_collector.sv
// Bench for neuron_spike_collector: reset check, table of single vectors,
// hand-written corner sequences and a randomized run against an event-list model.
module tb_neuron_spike_collector;

  localparam int DEPTH = 4;
  localparam int TS_W  = 8;
  localparam int W     = 13;  // {ts[7:0], addr[3:0], last}

  logic            clk = 1'b0;
  logic            rstb = 1'b0;
  logic            clr = 1'b0;
  logic            fs = 1'b0;
  logic            req = 1'b0;
  logic            rdy = 1'b0;
  logic [15:0]     nout = '0;
  logic            evt_valid;
  logic [TS_W-1:0] evt_ts;
  logic [3:0]      evt_addr;
  logic            evt_last;
  logic            ovf;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: expected events in order, and the time-step counter.
  logic [W-1:0] exp_q[$];
  logic [7:0]   m_ts = '0;

  typedef struct {
    logic [15:0] vec;
    int          n;
    logic [3:0]  first_a;
    logic [3:0]  last_a;
  } vec_t;

  vec_t tbl[8];

  int          n_ev;
  int          extra;
  logic [3:0]  first_a;
  logic [3:0]  last_a;
  logic        r;
  logic        rd;
  logic        f;
  logic [15:0] v;

  neuron_spike_collector #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .CLK         (clk),
    .RSTB        (rstb),
    .CLR         (clr),
    .FRAME_START (fs),
    .REQ         (req),
    .NEURON_OUT  (nout),
    .EVT_VALID   (evt_valid),
    .EVT_READY   (rdy),
    .EVT_TS      (evt_ts),
    .EVT_ADDR    (evt_addr),
    .EVT_LAST    (evt_last),
    .OVF         (ovf),
    .BUSY        (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_req(input logic [15:0] vec, input logic fstart);
    req  = 1'b1;
    nout = vec;
    fs   = fstart;
    tick();
    req  = 1'b0;
    nout = '0;
    fs   = 1'b0;
  endtask

  // Wait (bounded) for an event with READY high and compare it.
  task automatic expect_evt(input logic [7:0] ts, input logic [3:0] a, input logic l,
                            input string nm);
    int w;
    w = 0;
    while (!evt_valid && w < 40) begin
      tick();
      w++;
    end
    chk({nm, "_valid"}, 32'(evt_valid), 32'd1);
    chk({nm, "_evt"}, 32'({evt_ts, evt_addr, evt_last}), 32'({ts, a, l}));
    tick();
  endtask

  // Count events on the port over a number of cycles.
  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (evt_valid) cnt++;
      tick();
    end
  endtask

  function automatic int pending_vecs();
    int c;
    c = 0;
    foreach (exp_q[i]) if (exp_q[i][0]) c++;
    return c;
  endfunction

  // One cycle of model-checked operation: check the presented event, then
  // apply inputs; the model turns each sampled REQ into its list of events.
  task automatic step_model(input logic rq, input logic [15:0] vec, input logic fst,
                            input logic rdv);
    logic [7:0] tag;
    if (evt_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_evt", 32'(evt_valid), 32'd0);
      end else begin
        chk("model_evt", 32'({evt_ts, evt_addr, evt_last}), 32'(exp_q[0]));
        if (rdv) void'(exp_q.pop_front());
      end
    end
    if (rq) begin
      tag  = fst ? 8'd0 : m_ts;
      m_ts = tag + 8'd1;
      for (int i = 0; i < 16; i++) begin
        if (vec[i]) exp_q.push_back({tag, 4'(i), ((vec >> (i + 1)) == 16'd0)});
      end
    end else if (fst) begin
      m_ts = 8'd0;
    end
    rdy  = rdv;
    req  = rq;
    nout = vec;
    fs   = fst;
    tick();
  endtask

  initial begin
    tbl[0] = '{16'h8005, 3, 4'd0, 4'd15};
    tbl[1] = '{16'h0001, 1, 4'd0, 4'd0};
    tbl[2] = '{16'h8000, 1, 4'd15, 4'd15};
    tbl[3] = '{16'hFFFF, 16, 4'd0, 4'd15};
    tbl[4] = '{16'h0010, 1, 4'd4, 4'd4};
    tbl[5] = '{16'h0000, 0, 4'd0, 4'd0};
    tbl[6] = '{16'h5555, 8, 4'd0, 4'd14};
    tbl[7] = '{16'hA000, 2, 4'd13, 4'd15};

    // reset state
    tick();
    tick();
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ovf",   32'(ovf), 0);
    chk("rst_fields", 32'({evt_ts, evt_addr, evt_last}), 0);
    rstb = 1'b1;
    tick();

    // table of single vectors, READY high
    for (int t = 0; t < 8; t++) begin
      do_clr();
      rdy = 1'b1;
      do_req(tbl[t].vec, 1'b0);
      n_ev = 0;
      first_a = '0;
      last_a = '0;
      for (int c = 0; c < 24; c++) begin
        if (evt_valid) begin
          if (n_ev == 0) first_a = evt_addr;
          last_a = evt_addr;
          n_ev++;
          chk("tbl_ts", 32'(evt_ts), 0);
          chk("tbl_last", 32'(evt_last), 32'(n_ev == tbl[t].n));
        end
        tick();
      end
      chk("tbl_count", 32'(n_ev), 32'(tbl[t].n));
      if (tbl[t].n > 0) begin
        chk("tbl_first", 32'(first_a), 32'(tbl[t].first_a));
        chk("tbl_lasta", 32'(last_a), 32'(tbl[t].last_a));
      end
      chk("tbl_idle_busy", 32'(busy), 0);
    end

    // latency and one event per cycle for 16'h8005
    do_clr();
    rdy = 1'b1;
    req = 1'b1;
    nout = 16'h8005;
    tick();
    req = 1'b0;
    nout = '0;
    chk("lat_valid_k", 32'(evt_valid), 0);
    chk("lat_busy_k", 32'(busy), 1);
    tick();
    chk("lat_valid_k1", 32'(evt_valid), 1);
    chk("lat_ev0", 32'({evt_ts, evt_addr, evt_last}), 32'({8'd0, 4'd0, 1'b0}));
    tick();
    chk("lat_ev1", 32'({evt_valid, evt_ts, evt_addr, evt_last}), 32'({1'b1, 8'd0, 4'd2, 1'b0}));
    tick();
    chk("lat_ev2", 32'({evt_valid, evt_ts, evt_addr, evt_last}), 32'({1'b1, 8'd0, 4'd15, 1'b1}));
    tick();
    chk("lat_done_valid", 32'(evt_valid), 0);
    chk("lat_done_busy", 32'(busy), 0);

    // backpressure: outputs hold for 5 stalled cycles, then drain cleanly
    do_clr();
    rdy = 1'b0;
    do_req(16'h0421, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", 32'({evt_valid, evt_ts, evt_addr, evt_last}), 32'({1'b1, 8'd0, 4'd0, 1'b0}));
      tick();
    end
    rdy = 1'b1;
    chk("bp_ev0", 32'({evt_valid, evt_ts, evt_addr, evt_last}), 32'({1'b1, 8'd0, 4'd0, 1'b0}));
    tick();
    chk("bp_ev1", 32'({evt_valid, evt_ts, evt_addr, evt_last}), 32'({1'b1, 8'd0, 4'd5, 1'b0}));
    tick();
    chk("bp_ev2", 32'({evt_valid, evt_ts, evt_addr, evt_last}), 32'({1'b1, 8'd0, 4'd10, 1'b1}));
    tick();
    chk("bp_done", 32'(evt_valid), 0);

    // overflow: 6 back-to-back full vectors with READY low
    do_clr();
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) do_req(16'hFFFF, 1'b0);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_busy", 32'(busy), 1);
    rdy = 1'b1;
    for (int tg = 0; tg < 5; tg++) begin
      for (int b = 0; b < 16; b++) expect_evt(8'(tg), 4'(b), (b == 15), "ovf");
    end
    chk("ovf_no_sixth", 32'(evt_valid), 0);
    do_req(16'h0001, 1'b0);
    expect_evt(8'd6, 4'd0, 1'b1, "ovf_next_tag");
    chk("ovf_sticky", 32'(ovf), 1);
    do_clr();
    chk("ovf_cleared", 32'(ovf), 0);

    // zero vector advances the tag but yields no event
    do_clr();
    rdy = 1'b1;
    do_req(16'h0000, 1'b0);
    do_req(16'h0010, 1'b0);
    expect_evt(8'd1, 4'd4, 1'b1, "zero");
    count_valid(10, extra);
    chk("zero_extra", 32'(extra), 0);

    // tag wrap 255->0 and FRAME_START coincident with REQ
    do_clr();
    exp_q.delete();
    m_ts = '0;
    for (int i = 0; i < 300; i++) begin
      if (i == 0 || i == 255 || i == 256) v = 16'h0001;
      else if (i == 100) v = 16'h0300;
      else v = 16'h0000;
      step_model(1'b1, v, 1'b0, 1'b1);
    end
    step_model(1'b1, 16'h0001, 1'b1, 1'b1);
    step_model(1'b1, 16'h0002, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step_model(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("frame_drained", 32'(exp_q.size()), 0);

    // CLR mid-drain with 3 entries queued and a REQ in the same cycle
    do_clr();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) do_req(16'h0003, 1'b0);
    clr = 1'b1;
    req = 1'b1;
    nout = 16'h0004;
    tick();
    clr = 1'b0;
    req = 1'b0;
    nout = '0;
    chk("clr_valid", 32'(evt_valid), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_ovf", 32'(ovf), 0);
    rdy = 1'b1;
    count_valid(10, extra);
    chk("clr_stale", 32'(extra), 0);
    do_req(16'h0001, 1'b0);
    expect_evt(8'd0, 4'd0, 1'b1, "clr_tag");

    // asynchronous reset mid-drain
    do_clr();
    rdy = 1'b0;
    do_req(16'h0000, 1'b0);
    do_req(16'h0000, 1'b0);
    do_req(16'h0006, 1'b0);
    tick();
    chk("arst_pre", 32'({evt_valid, evt_ts, evt_addr}), 32'({1'b1, 8'd2, 4'd1}));
    #2;
    rstb = 1'b0;
    #1;
    chk("arst_out", 32'({evt_valid, busy, ovf, evt_ts, evt_addr, evt_last}), 0);
    tick();
    rstb = 1'b1;
    rdy = 1'b1;
    count_valid(5, extra);
    chk("arst_stale", 32'(extra), 0);
    do_req(16'h0001, 1'b0);
    expect_evt(8'd0, 4'd0, 1'b1, "arst_tag");

    // randomized run against the event-list model
    do_clr();
    exp_q.delete();
    m_ts = '0;
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(0, 3) != 0);
      r  = (pending_vecs() <= DEPTH) && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 4))
        0:       v = 16'h0000;
        1:       v = 16'h0001 << $urandom_range(0, 15);
        default: v = 16'($urandom());
      endcase
      f = ($urandom_range(0, 15) == 0);
      step_model(r, v, f, rd);
    end
    for (int i = 0; i < 200; i++) step_model(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("rand_drained", 32'(exp_q.size()), 0);
    chk("rand_busy", 32'(busy), 0);
    chk("rand_ovf", 32'(ovf), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
